// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues single-beat memory reads and buffers returned words for decode.
// Optional FETCH_PERF_CNT_EN adds FetchCount/StallCycles performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          PC_STEP    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] MemAddress,
    output logic        MemReadEnable,
    input  logic        MemAck,
    input  logic [31:0] MemInstr,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCycles
`endif
);

    localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]     STEP_C  = 32'(PC_STEP);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [31:0]   instr_q [FIFO_DEPTH];
    logic [31:0]   pc_q    [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop, issue;

    assign push       = (state == WAIT) && MemAck && !Redirect;
    assign pop        = InstrValid && InstrReady && !Redirect;
    assign InstrValid = (count != '0);
    assign Instr      = InstrValid ? instr_q[rd_ptr] : '0;
    assign InstrPC    = InstrValid ? pc_q[rd_ptr]    : '0;
    // PC only advances when a word lands, so it always names the outstanding request.
    assign MemAddress = pc;

    always_comb begin
        count_next = count;
        if (Redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!Redirect && !MemAck && (count_next < DEPTH_C)) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (MemAck) begin
                    state_next = IDLE;
                    if (!Redirect) begin
                        pc_next = pc + STEP_C;
                        // Back-to-back issue off the return keeps one word per two cycles.
                        if (count_next < DEPTH_C) begin
                            issue      = 1'b1;
                            state_next = WAIT;
                        end
                    end
                end else if (Redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (MemAck)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (Redirect)
            pc_next = RedirectPC & 32'hFFFF_FFFC;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            MemReadEnable <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            MemReadEnable <= issue;
            count         <= count_next;
            if (Redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Buffer storage carries no reset; the outputs are masked while empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_q[wr_ptr] <= MemInstr;
            pc_q[wr_ptr]    <= pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            FetchCount  <= '0;
            StallCycles <= '0;
        end else begin
            if (push)
                FetchCount <= FetchCount + 32'd1;
            if (InstrValid && !InstrReady)
                StallCycles <= StallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a one-cycle-latency memory model.
// Cycle 0 is the first cycle with MemReadEnable high after reset release.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST, Redirect, MemReadEnable, MemAck, InstrValid, InstrReady;
    logic [31:0] RedirectPC, MemAddress, MemInstr, Instr, InstrPC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCycles;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          viol   = 0;
    int          req_cyc  [$];
    logic [31:0] req_addr [$];
    logic [31:0] pop_pc   [$];
    logic        stable_ok, low_ok;

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .MemAddress   (MemAddress),
        .MemReadEnable(MemReadEnable),
        .MemAck       (MemAck),
        .MemInstr     (MemInstr),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount   (FetchCount),
        .StallCycles  (StallCycles)
`endif
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: log the request/pop of the current cycle, then model the memory return.
    task automatic tick();
        logic        req;
        logic [31:0] a;
        req = (MemReadEnable === 1'b1);
        a   = MemAddress;
        if (req) begin
            req_cyc.push_back(cyc);
            req_addr.push_back(a);
        end
        if (InstrValid === 1'b1 && InstrReady && !Redirect)
            pop_pc.push_back(InstrPC);
        @(posedge CLK);
        #1;
        cyc++;
        MemAck   = req;
        MemInstr = req ? word(a) : 32'h0;
        if (MemAck && MemReadEnable === 1'b1)
            viol++;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        InstrReady = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'b0, InstrValid}, 32'd0);
        chk("rst_mre",   {31'b0, MemReadEnable}, 32'd0);
        chk("rst_addr",  MemAddress, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_ipc",   InstrPC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetchcnt", FetchCount, 32'd0);
        chk("rst_stallcnt", StallCycles, 32'd0);
`endif
        RST = 1'b0;
        cyc = -1;
        req_cyc.delete();
        req_addr.delete();
        pop_pc.delete();
    endtask

    initial begin
        RST        = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        InstrReady = 1'b1;
        MemAck     = 1'b0;
        MemInstr   = 32'h0;

        // Streaming with decode always ready
        do_reset();
        repeat (7) begin
            tick();
            if (cyc == 2) begin
                chk("t1_valid_c2", {31'b0, InstrValid}, 32'd1);
                chk("t1_ipc_c2",   InstrPC, 32'h0);
                chk("t1_instr_c2", Instr, word(32'h0));
            end
        end
        chk("t1_nreq",   req_cyc.size(), 32'd3);
        chk("t1_req0_c", req_cyc[0], 32'd0);
        chk("t1_req1_c", req_cyc[1], 32'd2);
        chk("t1_req2_c", req_cyc[2], 32'd4);
        chk("t1_req0_a", req_addr[0], 32'h0);
        chk("t1_req1_a", req_addr[1], 32'h4);
        chk("t1_req2_a", req_addr[2], 32'h8);
        chk("t1_no_req_with_ack", viol, 32'd0);

        // Decode stalled: buffer fills, head stays stable, then drains
        do_reset();
        InstrReady = 1'b0;
        stable_ok  = 1'b1;
        repeat (11) begin
            tick();
            if (InstrValid === 1'b1 && (InstrPC !== 32'h0 || Instr !== word(32'h0)))
                stable_ok = 1'b0;
        end
        chk("t2_nreq_stalled", req_cyc.size(), 32'd2);
        chk("t2_head_stable",  {31'b0, stable_ok}, 32'd1);
        chk("t2_valid_full",   {31'b0, InstrValid}, 32'd1);
        InstrReady = 1'b1;
        repeat (4) tick();
        chk("t2_npop",  pop_pc.size(), 32'd3);
        chk("t2_pop0",  pop_pc[0], 32'h0);
        chk("t2_pop1",  pop_pc[1], 32'h4);
        chk("t2_pop2",  pop_pc[2], 32'h8);
        chk("t2_req2_a", req_addr[2], 32'h8);
        chk("t2_req2_c", req_cyc[2], 32'd11);

        // Redirect while waiting, return arrives the next cycle
        do_reset();
        tick();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0103;
        tick();
        Redirect = 1'b0;
        low_ok   = 1'b1;
        while (cyc < 5) begin
            if (InstrValid !== 1'b0) low_ok = 1'b0;
            tick();
        end
        chk("t3_valid_low", {31'b0, low_ok}, 32'd1);
        chk("t3_nreq",      req_cyc.size(), 32'd2);
        chk("t3_req1_a",    req_addr[1], 32'h0000_0100);
        chk("t3_req1_c",    req_cyc[1], 32'd3);
        chk("t3_valid",     {31'b0, InstrValid}, 32'd1);
        chk("t3_ipc",       InstrPC, 32'h0000_0100);
        chk("t3_instr",     Instr, word(32'h0000_0100));

        // Redirect in the same cycle as the return
        do_reset();
        tick();
        tick();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_2000;
        tick();
        Redirect = 1'b0;
        chk("t4_valid_c2", {31'b0, InstrValid}, 32'd0);
        chk("t4_mre_c2",   {31'b0, MemReadEnable}, 32'd0);
        tick();
        chk("t4_mre_c3",   {31'b0, MemReadEnable}, 32'd1);
        chk("t4_addr_c3",  MemAddress, 32'h0000_2000);
        chk("t4_valid_c3", {31'b0, InstrValid}, 32'd0);

        // Redirect flushes a full buffer; PC wraps past the top of memory
        do_reset();
        InstrReady = 1'b0;
        while (cyc < 5) tick();
        chk("t5_valid_full", {31'b0, InstrValid}, 32'd1);
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFE;
        tick();
        Redirect = 1'b0;
        chk("t5_flushed", {31'b0, InstrValid}, 32'd0);
        tick();
        chk("t5_mre_top",  {31'b0, MemReadEnable}, 32'd1);
        chk("t5_addr_top", MemAddress, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("t5_addr_wrap", MemAddress, 32'h0);
        chk("t5_mre_wrap",  {31'b0, MemReadEnable}, 32'd1);
        chk("t5_ipc_top",   InstrPC, 32'hFFFF_FFFC);

        // Reset while a request is outstanding; the late return is ignored
        do_reset();
        while (cyc < 2) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t6_mre_c3",   {31'b0, MemReadEnable}, 32'd0);
        chk("t6_addr_c3",  MemAddress, 32'h0);
        chk("t6_valid_c3", {31'b0, InstrValid}, 32'd0);
        tick();
        chk("t6_valid_c4", {31'b0, InstrValid}, 32'd0);
        chk("t6_mre_c4",   {31'b0, MemReadEnable}, 32'd0);
        tick();
        chk("t6_mre_c5",   {31'b0, MemReadEnable}, 32'd1);
        chk("t6_addr_c5",  MemAddress, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        // Three fetches with five stalled cycles
        do_reset();
        InstrReady = 1'b0;
        while (cyc < 7) tick();
        InstrReady = 1'b1;
        while (cyc < 10) tick();
        chk("t7_fetchcnt", FetchCount, 32'd3);
        chk("t7_stallcnt", StallCycles, 32'd5);
`endif

        chk("all_no_req_with_ack", viol, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
